comparator_core: RTL and testbench
==================================

// Module: comparator_core
// PURPOSE
// - Registered WIDTH-bit magnitude/equality comparator. Compares operands x and y; z is the primary equality flag (z=1 iff x==y).
// - Also reports less-than / greater-than, in unsigned or two's-complement mode.
// - Datapath leaf used wherever a registered compare result with a valid qualifier is needed.
// PARAMETERS
// - WIDTH      4   operand width in bits, >=1
// - SIGNED_EN  1   1: include signed-mode logic; 0: is_signed ignored, unsigned only
// PORTS
// - clk        in   1      single clock, all state on rising edge
// - rst_n      in   1      reset, synchronous, active-low
// - in_valid   in   1      x/y/is_signed valid this cycle
// - is_signed  in   1      1: two's-complement compare; 0: unsigned
// - x          in   WIDTH  operand A
// - y          in   WIDTH  operand B
// - out_valid  out  1      result registers hold a new result
// - z          out  1      x == y
// - lt         out  1      x < y (per mode)
// - gt         out  1      x > y (per mode)
// BEHAVIOUR
// - Interface: one clock; reset synchronous, active-low (clk, rst_n).
// - Reset (rst_n=0 at posedge): out_valid=0, z=0, lt=0, gt=0. Reset wins over a simultaneous in_valid.
// - Latency 1 cycle.
//   - If in_valid=1 at posedge N, results for that x/y appear after edge N and out_valid=1 for exactly that cycle.
//   - Back-to-back inputs each produce one result per cycle, with no bubbles.
// - If in_valid=0: out_valid goes to 0; z/lt/gt hold their last values.
// - No backpressure; the block always accepts input.
// - Exactly one of z, lt, gt is 1 whenever out_valid=1 (one-hot).
// - Equality: z = &(x ~^ y). Mode-independent.
// - Unsigned: plain magnitude compare.
// - Signed (is_signed=1, SIGNED_EN=1): MSBs differ -> operand with MSB=1 is smaller; otherwise unsigned compare of the bits.
// - Compare implementation: MSB-first priority of per-bit slices. Do not use a WIDTH+1 subtractor.
// - Boundaries:
//   - WIDTH=1 must work.
//   - all-ones vs zero: unsigned gt=1, signed lt=1.
//   - min negative vs max positive: signed lt=1.
//   - x/y containing X/Z: outputs undefined, not checked.
// - Reset deasserted mid-stream: the first in_valid after release produces a normal result one cycle later; no stale results.
// STRUCTURE
// - Shared package cmp_pkg:
//   - typedef cmp_res_t (2-bit encoding EQ=2'b00, LT=2'b01, GT=2'b10)
//   - function decoding cmp_res_t to {z, lt, gt}
// - One sub-module, cmp_slice:
//   - per-bit cell producing {eq_i, lt_i, gt_i}
//   - generate-chained MSB->LSB inside comparator_core
//   - MSB slice inverted when signed mode is active
// - Output register stage lives in comparator_core.
// TESTING
// - x=0000, y=0000, in_valid=1, unsigned -> next cycle z=1, lt=0, gt=0, out_valid=1.
// - x=0001, y=0000 -> z=0, gt=1. Then x=1010, y=1010 -> z=1. Then x=1100, y=1110 -> z=0, lt=1. Applied back-to-back, three consecutive valid results.
// - x=1111, y=0000: unsigned -> gt=1; signed -> lt=1. Also x=1000, y=0111 signed -> lt=1.
// - in_valid=1 with rst_n=0 -> out_valid=0, z=lt=gt=0. Release reset, apply x=y=0101 -> z=1 one cycle later.
// - in_valid pulse then idle -> out_valid drops, z/lt/gt hold. Random 10k vectors vs reference model: one-hot holds.
// - WIDTH=1 and WIDTH=16 builds: exhaustive (W=1) and random (W=16) checks pass.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the comparator: the 2-bit compare result encoding and
// its decode into the {z, lt, gt} flag triple.
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_LT = 2'b01,
    CMP_GT = 2'b10
  } cmp_res_t;

  // Returns {z, lt, gt}; the unused 2'b11 code decodes as equal.
  function automatic logic [2:0] cmp_decode(input cmp_res_t r);
    case (r)
      CMP_LT:  return 3'b010;
      CMP_GT:  return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/comparator_core_if.sv
// Operand/result bundle for comparator_core: the master drives operands,
// the slave (the comparator) returns the registered flags.
interface comparator_core_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             is_signed;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             z;
  logic             lt;
  logic             gt;

  modport master (
    output in_valid, is_signed, x, y,
    input  out_valid, z, lt, gt
  );

  modport slave (
    input  in_valid, is_signed, x, y,
    output out_valid, z, lt, gt
  );
endinterface

// File: rtl/cmp_slice.sv
// One-bit compare cell. With i_inv set, the lt/gt sense is swapped so that a
// set sign bit ranks as the smaller operand.
module cmp_slice (
  input  logic i_a,
  input  logic i_b,
  input  logic i_inv,
  output logic o_eq,
  output logic o_lt,
  output logic o_gt
);
  logic w_a_lo;
  logic w_a_hi;

  assign w_a_lo = ~i_a & i_b;
  assign w_a_hi = i_a & ~i_b;

  assign o_eq = ~(i_a ^ i_b);
  assign o_lt = i_inv ? w_a_hi : w_a_lo;
  assign o_gt = i_inv ? w_a_lo : w_a_hi;
endmodule

// File: rtl/comparator_core.sv
// Registered magnitude/equality comparator: per-bit slices chained MSB-first
// feed a single output register stage with a valid qualifier.
module comparator_core
  import cmp_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  comparator_core_if.slave  bus
);

  logic       w_signed;
  cmp_res_t   w_chain [WIDTH:0];
  logic [2:0] w_flags;

  logic       r_valid;
  logic       r_z;
  logic       r_lt;
  logic       r_gt;

  assign w_signed   = SIGNED_EN && bus.is_signed;
  assign w_chain[0] = CMP_EQ;

  // Each higher bit overrides the verdict of the bits below it unless equal.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
    logic w_eq;
    logic w_lt;
    logic w_gt;

    cmp_slice u_slice (
      .i_a   (bus.x[gi]),
      .i_b   (bus.y[gi]),
      .i_inv ((gi == WIDTH - 1) ? w_signed : 1'b0),
      .o_eq  (w_eq),
      .o_lt  (w_lt),
      .o_gt  (w_gt)
    );

    assign w_chain[gi+1] = w_eq ? w_chain[gi] :
                           w_lt ? CMP_LT      :
                           w_gt ? CMP_GT      : w_chain[gi];
  end

  assign w_flags = cmp_decode(w_chain[WIDTH]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_z     <= 1'b0;
      r_lt    <= 1'b0;
      r_gt    <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_z  <= w_flags[2];
        r_lt <= w_flags[1];
        r_gt <= w_flags[0];
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.z         = r_z;
  assign bus.lt        = r_lt;
  assign bus.gt        = r_gt;

endmodule

// File: tb/tb_comparator_core.sv
// Scoreboard bench for comparator_core (WIDTH=4): directed vectors push
// expected {z,lt,gt} into a queue that a monitor drains on every out_valid.
module tb_comparator_core;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] q_exp[$];

  comparator_core_if #(.WIDTH(W)) bus ();

  comparator_core #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         s;
    logic [2:0]   exp;   // {z, lt, gt}
  } vec_t;

  vec_t vecs[$] = '{
    '{4'b0000, 4'b0000, 1'b0, 3'b100},
    '{4'b0001, 4'b0000, 1'b0, 3'b001},
    '{4'b1010, 4'b1010, 1'b0, 3'b100},
    '{4'b1100, 4'b1110, 1'b0, 3'b010},
    '{4'b1111, 4'b0000, 1'b0, 3'b001},
    '{4'b1111, 4'b0000, 1'b1, 3'b010},
    '{4'b1000, 4'b0111, 1'b1, 3'b010},
    '{4'b0111, 4'b1000, 1'b1, 3'b001},
    '{4'b1000, 4'b0111, 1'b0, 3'b001},
    '{4'b1110, 4'b1101, 1'b1, 3'b001},
    '{4'b0011, 4'b0101, 1'b1, 3'b010}
  };

  function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic s);
    if (a == b) return 3'b100;
    if (s ? ($signed(a) < $signed(b)) : (a < b)) return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [2:0] exp);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.x         = a;
    bus.y         = b;
    bus.is_signed = s;
    q_exp.push_back(exp);
    $display("issue x=%b y=%b signed=%0d exp_zlg=%b", a, b, s, exp);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Monitor: samples just after each rising edge, independent of the driver.
  initial begin
    logic [2:0] act;
    logic [2:0] exp;
    forever begin
      @(posedge clk);
      #2;
      if (bus.out_valid === 1'b1) begin
        act = {bus.z, bus.lt, bus.gt};
        if (q_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual_zlg=%b required=none", act);
        end else begin
          exp = q_exp.pop_front();
          chk("result_zlg", int'(act), int'(exp));
          chk("one_hot", int'($countones(act)), 1);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         rs;
    logic [2:0]   last;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.is_signed = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", int'(bus.out_valid), 0);
    chk("reset_zlg", int'({bus.z, bus.lt, bus.gt}), 0);
    rst_n = 1'b1;

    // Directed vectors back-to-back, no bubbles.
    foreach (vecs[i]) issue(vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].exp);
    idle();
    @(negedge clk);
    chk("idle_valid", int'(bus.out_valid), 0);
    chk("idle_hold_zlg", int'({bus.z, bus.lt, bus.gt}), 3'b010);

    // Reset wins over a simultaneous valid input.
    bus.in_valid = 1'b1;
    bus.x        = 4'b0101;
    bus.y        = 4'b0101;
    rst_n        = 1'b0;
    @(negedge clk);
    chk("rst_vs_valid_valid", int'(bus.out_valid), 0);
    chk("rst_vs_valid_zlg", int'({bus.z, bus.lt, bus.gt}), 0);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    issue(4'b0101, 4'b0101, 1'b0, 3'b100);
    idle();
    @(negedge clk);
    chk("post_reset_hold_z", int'(bus.z), 1);

    // Random vectors against the behavioural model, with occasional bubbles.
    last = 3'b100;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        idle();
      end else begin
        rx   = W'($urandom);
        ry   = W'($urandom);
        rs   = 1'($urandom);
        last = model(rx, ry, rs);
        issue(rx, ry, rs, last);
      end
    end
    idle();
    @(negedge clk);
    chk("final_hold_zlg", int'({bus.z, bus.lt, bus.gt}), int'(last));
    repeat (2) @(negedge clk);
    chk("drain_queue", q_exp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
